// File: rtl/v_row_sequencer.sv
// rtl/v_row_sequencer.sv - burst row walker for the four-bank vector arbiter with buffered stream output
module v_row_sequencer #(
   parameter int READ_LAT   = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [10:0] start_row,
   input  logic [10:0] num_rows,
   input  logic        half_sel,
   output logic [10:0] rowno,
   output logic        count2,
   output logic        row_issue,
   input  logic [47:0] vout_in,
   output logic [47:0] vec_data,
   output logic        vec_valid,
   input  logic        vec_ready,
   output logic        vec_last,
   output logic        busy,
   output logic        done
);

   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_READ   = 2'd1;
   localparam logic [1:0] S_WAITSP = 2'd2;
   localparam logic [1:0] S_DRAIN  = 2'd3;

   logic [1:0]    state;
   logic [2:0]    lat_cnt;
   logic [10:0]   remaining;
   logic          burst_done;
   logic          zero_done;

   logic [48:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   fcount;
   logic [AW:0]   fcount_next;

   logic          push;
   logic          pop;
   logic          final_row;
   logic          head_last;

   assign push        = (state == S_READ) && (lat_cnt == 3'(READ_LAT));
   assign pop         = vec_valid && vec_ready;
   assign final_row   = (remaining == 11'd1);
   assign fcount_next = fcount + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
   assign head_last   = mem[rd_ptr][48];

   assign vec_valid = (fcount != '0);
   assign vec_last  = vec_valid && head_last;
   assign vec_data  = vec_valid ? mem[rd_ptr][47:0] : 48'd0;
   assign row_issue = (state == S_READ) && (lat_cnt == 3'd0);
   // done from a real burst lands in IDLE, so busy must still cover that cycle
   assign busy      = (state != S_IDLE) || burst_done;
   assign done      = burst_done || zero_done;

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= {final_row, vout_in};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fcount <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         fcount <= fcount_next;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         rowno      <= 11'd0;
         count2     <= 1'b0;
         lat_cnt    <= 3'd0;
         remaining  <= 11'd0;
         burst_done <= 1'b0;
         zero_done  <= 1'b0;
      end else begin
         burst_done <= 1'b0;
         zero_done  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !burst_done) begin
                  if (num_rows != 11'd0) begin
                     rowno     <= start_row;
                     count2    <= half_sel;
                     remaining <= num_rows;
                     lat_cnt   <= 3'd0;
                     state     <= S_READ;
                  end else begin
                     zero_done <= 1'b1;
                  end
               end
            end
            S_READ: begin
               if (push) begin
                  remaining <= remaining - 11'd1;
                  if (final_row) begin
                     state <= S_DRAIN;
                  end else begin
                     // rowno advances even when stalling so WAITSP holds the next row
                     rowno   <= rowno + 11'd1;
                     lat_cnt <= 3'd0;
                     if (fcount_next >= (AW+1)'(FIFO_DEPTH)) begin
                        state <= S_WAITSP;
                     end
                  end
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end
            S_WAITSP: begin
               if (fcount < (AW+1)'(FIFO_DEPTH)) begin
                  lat_cnt <= 3'd0;
                  state   <= S_READ;
               end
            end
            S_DRAIN: begin
               if (pop && head_last) begin
                  burst_done <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_v_row_sequencer.sv
// tb/tb_v_row_sequencer.sv - directed vector bench for v_row_sequencer
module tb_v_row_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [10:0] start_row;
   logic [10:0] num_rows;
   logic        half_sel;
   logic [10:0] rowno;
   logic        count2;
   logic        row_issue;
   logic [47:0] vout_in;
   logic [47:0] vec_data;
   logic        vec_valid;
   logic        vec_ready;
   logic        vec_last;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [10:0] q_rows [$];
   logic [47:0] q_data [$];
   logic        q_last [$];
   int          done_cnt;
   int          busy_cnt;
   int          c2_bad;
   logic        exp_c2;

   always #5 clock = ~clock;

   v_row_sequencer #(.READ_LAT(1), .FIFO_DEPTH(4)) dut (
      .clock(clock), .reset(reset), .start(start), .start_row(start_row),
      .num_rows(num_rows), .half_sel(half_sel), .rowno(rowno), .count2(count2),
      .row_issue(row_issue), .vout_in(vout_in), .vec_data(vec_data),
      .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_last(vec_last),
      .busy(busy), .done(done)
   );

   // arbiter stand-in: distinct bank pattern in the top field
   function automatic logic [47:0] arb_model(input logic [10:0] r, input logic c);
      return {16'hB000 | {14'd0, r[1:0]}, 15'd0, c, 5'd0, r};
   endfunction

   assign vout_in = arb_model(rowno, count2);

   always @(negedge clock) begin
      if (vec_valid && vec_ready) begin
         q_data.push_back(vec_data);
         q_last.push_back(vec_last);
      end
      if (row_issue) q_rows.push_back(rowno);
      if (done) done_cnt++;
      if (busy) begin
         busy_cnt++;
         if (count2 !== exp_c2) c2_bad++;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_mon();
      q_rows.delete();
      q_data.delete();
      q_last.delete();
      done_cnt = 0;
      busy_cnt = 0;
      c2_bad   = 0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rowno"}, 64'(rowno), 64'd0);
      check({tag, "_count2"}, 64'(count2), 64'd0);
      check({tag, "_row_issue"}, 64'(row_issue), 64'd0);
      check({tag, "_vec_valid"}, 64'(vec_valid), 64'd0);
      check({tag, "_vec_last"}, 64'(vec_last), 64'd0);
      check({tag, "_vec_data"}, 64'(vec_data), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
   endtask

   task automatic run_until_done(input string tag, input int budget);
      bit got = 0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clock);
         if (done) got = 1;
         step();
      end
      check({tag, "_done_seen"}, 64'(got), 64'd1);
      step();
      step();
   endtask

   task automatic check_burst(input string tag, input logic [10:0] first, input int n, input logic c);
      logic [10:0] r;
      check({tag, "_nrows"}, 64'(q_rows.size()), 64'(n));
      check({tag, "_nwords"}, 64'(q_data.size()), 64'(n));
      for (int i = 0; i < n; i++) begin
         r = first + 11'(i);
         if (i < q_rows.size()) check($sformatf("%s_row%0d", tag, i), 64'(q_rows[i]), 64'(r));
         if (i < q_data.size()) begin
            check($sformatf("%s_data%0d", tag, i), 64'(q_data[i]), 64'(arb_model(r, c)));
            check($sformatf("%s_last%0d", tag, i), 64'(q_last[i]), 64'(i == n - 1));
         end
      end
   endtask

   typedef struct {
      logic        start;
      logic [10:0] rowno;
      logic        issue;
      logic        busy;
      logic        valid;
      logic        last;
      logic        done;
      logic [10:0] drow;
   } vec_t;

   vec_t tbl [12];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //        start rowno iss busy val last done drow
      tbl[0]  = '{1'b1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0};
      tbl[1]  = '{1'b0, 11'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0};
      tbl[2]  = '{1'b0, 11'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0};
      tbl[3]  = '{1'b0, 11'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'd5};
      tbl[4]  = '{1'b0, 11'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0};
      tbl[5]  = '{1'b0, 11'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'd6};
      tbl[6]  = '{1'b0, 11'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0};
      tbl[7]  = '{1'b0, 11'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'd7};
      tbl[8]  = '{1'b0, 11'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0};
      tbl[9]  = '{1'b0, 11'd8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 11'd8};
      tbl[10] = '{1'b0, 11'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd0};
      tbl[11] = '{1'b0, 11'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0};

      reset = 1'b1; start = 1'b0; start_row = 11'd0; num_rows = 11'd0;
      half_sel = 1'b0; vec_ready = 1'b1; exp_c2 = 1'b0;
      clear_mon();
      step();
      step();
      @(negedge clock);
      check_reset_vals("reset");
      step();
      reset = 1'b0;

      // basic burst, cycle-exact
      start_row = 11'd5; num_rows = 11'd4; half_sel = 1'b0;
      for (int i = 0; i < 12; i++) begin
         start = tbl[i].start;
         @(negedge clock);
         check($sformatf("basic_c%0d_rowno", i), 64'(rowno), 64'(tbl[i].rowno));
         check($sformatf("basic_c%0d_issue", i), 64'(row_issue), 64'(tbl[i].issue));
         check($sformatf("basic_c%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
         check($sformatf("basic_c%0d_valid", i), 64'(vec_valid), 64'(tbl[i].valid));
         check($sformatf("basic_c%0d_last", i), 64'(vec_last), 64'(tbl[i].last));
         check($sformatf("basic_c%0d_done", i), 64'(done), 64'(tbl[i].done));
         if (tbl[i].valid)
            check($sformatf("basic_c%0d_data", i), 64'(vec_data), 64'(arb_model(tbl[i].drow, 1'b0)));
         step();
      end

      // wrap with upper half selected
      clear_mon();
      exp_c2 = 1'b1;
      start_row = 11'd2046; num_rows = 11'd3; half_sel = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      run_until_done("wrap", 40);
      check_burst("wrap", 11'd2046, 3, 1'b1);
      check("wrap_count2", 64'(c2_bad), 64'd0);
      check("wrap_done_cnt", 64'(done_cnt), 64'd1);

      // backpressure
      clear_mon();
      exp_c2 = 1'b0; half_sel = 1'b0; vec_ready = 1'b0;
      start_row = 11'd100; num_rows = 11'd8; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 29; i++) step();
      @(negedge clock);
      check("bp_rowno", 64'(rowno), 64'd104);
      check("bp_issued", 64'(q_rows.size()), 64'd4);
      check("bp_issue_low", 64'(row_issue), 64'd0);
      check("bp_busy", 64'(busy), 64'd1);
      check("bp_valid", 64'(vec_valid), 64'd1);
      check("bp_head", 64'(vec_data), 64'(arb_model(11'd100, 1'b0)));
      step();
      vec_ready = 1'b1;
      run_until_done("bp", 100);
      check_burst("bp", 11'd100, 8, 1'b0);
      check("bp_done_cnt", 64'(done_cnt), 64'd1);

      // zero length
      clear_mon();
      num_rows = 11'd0; start_row = 11'd9; start = 1'b1;
      step();
      start = 1'b0;
      @(negedge clock);
      check("zero_done_c1", 64'(done), 64'd1);
      check("zero_busy_c1", 64'(busy), 64'd0);
      step();
      @(negedge clock);
      check("zero_done_c2", 64'(done), 64'd0);
      for (int i = 0; i < 4; i++) step();
      check("zero_issues", 64'(q_rows.size()), 64'd0);
      check("zero_busy_cnt", 64'(busy_cnt), 64'd0);
      check("zero_done_cnt", 64'(done_cnt), 64'd1);

      // reset mid-burst
      start_row = 11'd20; num_rows = 11'd10;
      for (int c = 0; c < 8; c++) begin
         start = (c == 0);
         reset = (c == 6);
         @(negedge clock);
         if (c == 7) check_reset_vals("midrst");
         step();
         if (c == 6) clear_mon();
      end
      reset = 1'b0;
      for (int i = 0; i < 20; i++) step();
      check("midrst_no_done", 64'(done_cnt), 64'd0);
      check("midrst_no_issue", 64'(q_rows.size()), 64'd0);
      clear_mon();
      start_row = 11'd7; num_rows = 11'd2; start = 1'b1;
      step();
      start = 1'b0;
      run_until_done("after_rst", 40);
      check_burst("after_rst", 11'd7, 2, 1'b0);

      // start while busy: pulses in READ (c2) and DRAIN (c7)
      clear_mon();
      for (int c = 0; c < 13; c++) begin
         start     = (c == 0) || (c == 2) || (c == 7);
         start_row = (c == 0) ? 11'd40 : 11'd500;
         num_rows  = (c == 0) ? 11'd3 : 11'd5;
         half_sel  = (c != 0);
         @(negedge clock);
         if (c == 7) check("swb_c7_drain", 64'({busy, row_issue}), 64'b10);
         if (c == 8) check("swb_c8_done", 64'(done), 64'd1);
         if (c == 12) check("swb_c12_idle", 64'(busy), 64'd0);
         step();
      end
      start = 1'b0;
      check_burst("swb", 11'd40, 3, 1'b0);
      check("swb_done_cnt", 64'(done_cnt), 64'd1);
      check("swb_count2", 64'(c2_bad), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
